ddr2_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the DDR2 controller's single client port (64-bit data, 26-bit address, level request / one-cycle ack) between NUM_PORTS requesters.
- Sits between client logic (CPU fetch, DMA, video) and the DDR2 controller.
- Holds the winner's address, data and request stable for the whole controller transaction.
- Returns read data and a per-port ack pulse to the winner; flags transactions the controller never acknowledges.

---
 rtl/ddr2_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_ddr2_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_port_arbiter.sv
// Round-robin arbiter sharing the DDR2 controller client port between NUM_PORTS requesters.
// The winner's transaction is latched and held stable until the controller has drained it.
//
//   state   | meaning
//   S_IDLE  | no transaction; grant a requester when the controller is ready
//   S_REQ   | request held towards controller, waiting for m_ack
//   S_DRAIN | acked; address/data held until controller reports ready again
module ddr2_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          p_rd_req,
  input  logic [NUM_PORTS-1:0]          p_wr_req,
  input  logic [NUM_PORTS*26-1:0]       p_addr,
  input  logic [NUM_PORTS*64-1:0]       p_wdata,
  output logic [NUM_PORTS-1:0]          p_ack,
  output logic [63:0]                   p_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]  grant,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [25:0]                   m_addr,
  output logic [63:0]                   m_data_in,
  output logic                          m_rd_req,
  output logic                          m_wr_req,
  input  logic                          m_rdy,
  input  logic                          m_ack,
  input  logic [63:0]                   m_data_out
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        grant_nxt, win_idx, cand;
  logic                 win_found;
  logic [25:0]          addr_nxt;
  logic [63:0]          data_nxt, rdata_nxt;
  logic                 rd_nxt, wr_nxt, err_nxt;
  logic [NUM_PORTS-1:0] ack_nxt, req;
  logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;

  logic [25:0] addr_a  [NUM_PORTS];
  logic [63:0] wdata_a [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_a[i]  = p_addr[26*i +: 26];
    assign wdata_a[i] = p_wdata[64*i +: 64];
  end

  assign req = p_rd_req | p_wr_req;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    addr_nxt  = m_addr;
    data_nxt  = m_data_in;
    rd_nxt    = m_rd_req;
    wr_nxt    = m_wr_req;
    ack_nxt   = '0;
    rdata_nxt = p_rdata;
    err_nxt   = err_timeout;
    cnt_nxt   = cnt;
    win_found = 1'b0;
    win_idx   = grant;
    cand      = grant;

    // Scan starting one past the last winner so every requester gets its turn.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = GW'((int'(grant) + k) % NUM_PORTS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

    unique case (state)
      S_IDLE: begin
        if (m_rdy && win_found) begin
          grant_nxt = win_idx;
          addr_nxt  = addr_a[win_idx];
          data_nxt  = wdata_a[win_idx];
          rd_nxt    = p_rd_req[win_idx];
          wr_nxt    = !p_rd_req[win_idx];
          cnt_nxt   = '0;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (m_ack) begin
          rd_nxt         = 1'b0;
          wr_nxt         = 1'b0;
          ack_nxt[grant] = 1'b1;
          if (m_rd_req) rdata_nxt = m_data_out;
          state_nxt      = S_DRAIN;
        end else begin
          cnt_nxt = cnt_inc;
          // Flag only; the controller may still answer, so the request stays up.
          if (TIMEOUT != 0 && cnt_inc >= TO_VAL) err_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (m_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= GW'(NUM_PORTS - 1);
      m_addr      <= '0;
      m_data_in   <= '0;
      m_rd_req    <= 1'b0;
      m_wr_req    <= 1'b0;
      p_ack       <= '0;
      p_rdata     <= '0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      m_addr      <= addr_nxt;
      m_data_in   <= data_nxt;
      m_rd_req    <= rd_nxt;
      m_wr_req    <= wr_nxt;
      p_ack       <= ack_nxt;
      p_rdata     <= rdata_nxt;
      err_timeout <= err_nxt;
      cnt         <= cnt_nxt;
      busy        <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Bench for ddr2_port_arbiter: directed scenarios plus random traffic, all outputs compared
// every cycle against a transaction-level reference of the arbiter and a simple controller model.
module tb_ddr2_port_arbiter;

  localparam int NP = 3;
  localparam int TO = 16;
  localparam int GW = $clog2(NP);

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     p_rd_req, p_wr_req, p_ack;
  logic [NP*26-1:0]  p_addr;
  logic [NP*64-1:0]  p_wdata;
  logic [63:0]       p_rdata, m_data_in, m_data_out;
  logic [GW-1:0]     grant;
  logic              busy, err_timeout, m_rd_req, m_wr_req, m_rdy, m_ack;
  logic [25:0]       m_addr;

  // requester-side stimulus
  logic [25:0] a_addr  [NP];
  logic [63:0] a_wdata [NP];
  logic        a_rd    [NP];
  logic        a_wr    [NP];
  logic        auto_en [NP];
  int          gap     [NP];
  int          gap_max;

  for (genvar i = 0; i < NP; i++) begin : g_pack
    assign p_addr[i*26 +: 26]  = a_addr[i];
    assign p_wdata[i*64 +: 64] = a_wdata[i];
    assign p_rd_req[i]         = a_rd[i];
    assign p_wr_req[i]         = a_wr[i];
  end

  ddr2_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p_rd_req(p_rd_req), .p_wr_req(p_wr_req), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(p_ack), .p_rdata(p_rdata), .grant(grant), .busy(busy), .err_timeout(err_timeout),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd_req(m_rd_req), .m_wr_req(m_wr_req),
    .m_rdy(m_rdy), .m_ack(m_ack), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference: phase of the shared port, last winner, expected registered outputs
  typedef enum {M_IDLE, M_WAIT, M_DRAIN} mph_t;
  mph_t        ph;
  int          last_g, wait_n;
  logic [NP-1:0] e_pack;
  logic [63:0] e_rdata, e_wdata;
  logic [25:0] e_addr;
  logic        e_rd, e_wr, e_err;

  // controller model
  int          ack_lat, ctl_wait, drain_len, drain_left, refresh_left;
  logic [63:0] rd_word;
  logic        rand_ctl;
  logic        prev_req;
  int          glog[$];

  function automatic int rr_pick(input int last, input logic [NP-1:0] r);
    logic [NP-1:0] sh;
    for (int k = 1; k <= NP; k++) begin
      sh = r >> ((last + k) % NP);
      if (sh[0]) return (last + k) % NP;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    logic [GW-1:0] wi;
    if (rst) begin
      ph = M_IDLE; last_g = NP - 1; wait_n = 0;
      e_pack = '0; e_rdata = '0; e_wdata = '0; e_addr = '0;
      e_rd = 1'b0; e_wr = 1'b0; e_err = 1'b0;
      return;
    end
    e_pack = '0;
    case (ph)
      M_IDLE: begin
        w = rr_pick(last_g, p_rd_req | p_wr_req);
        if (m_rdy && w >= 0) begin
          wi = GW'(w);
          last_g = w; e_addr = a_addr[wi]; e_wdata = a_wdata[wi];
          e_rd = a_rd[wi]; e_wr = !a_rd[wi]; wait_n = 0; ph = M_WAIT;
        end
      end
      M_WAIT: begin
        if (m_ack) begin
          if (e_rd) e_rdata = m_data_out;
          e_pack[GW'(last_g)] = 1'b1;
          e_rd = 1'b0; e_wr = 1'b0; ph = M_DRAIN;
        end else begin
          wait_n++;
          if (wait_n >= TO) e_err = 1'b1;
        end
      end
      M_DRAIN: if (m_rdy) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("p_ack",       64'(p_ack), 64'(e_pack));
    chk("p_rdata",     p_rdata, e_rdata);
    chk("grant",       64'(grant), 64'(last_g));
    chk("busy",        64'(busy), 64'(ph != M_IDLE));
    chk("err_timeout", 64'(err_timeout), 64'(e_err));
    chk("m_addr",      64'(m_addr), 64'(e_addr));
    chk("m_data_in",   m_data_in, e_wdata);
    chk("m_rd_req",    64'(m_rd_req), 64'(e_rd));
    chk("m_wr_req",    64'(m_wr_req), 64'(e_wr));
  endtask

  task automatic new_req(input int i);
    int op;
    op = $urandom_range(0, 3);
    a_rd[i]    = (op != 1);
    a_wr[i]    = (op == 1 || op == 2);
    a_addr[i]  = 26'($urandom);
    a_wdata[i] = {$urandom, $urandom};
  endtask

  task automatic drive();
    logic busy_req;
    busy_req = m_rd_req | m_wr_req;
    m_ack = 1'b0;
    if (busy_req) begin
      if (ack_lat >= 0 && ctl_wait >= ack_lat) begin
        m_ack = 1'b1; m_data_out = rd_word; ctl_wait = 0; drain_left = drain_len;
        if (rand_ctl) begin
          ack_lat = $urandom_range(0, 10); drain_len = $urandom_range(0, 4);
          rd_word = {$urandom, $urandom};
        end
      end else ctl_wait++;
    end else if (rand_ctl && $urandom_range(0, 19) == 0) begin
      m_ack = 1'b1; m_data_out = {$urandom, $urandom};   // stray ack outside a request
    end
    if (refresh_left > 0) begin
      m_rdy = 1'b0; refresh_left--;
    end else if (busy_req || drain_left > 0) begin
      m_rdy = 1'b0;
      if (!busy_req) drain_left--;
    end else begin
      m_rdy = 1'b1;
      if (rand_ctl && $urandom_range(0, 29) == 0) refresh_left = $urandom_range(1, 12);
    end
    for (int i = 0; i < NP; i++) begin
      if (p_ack[i]) begin
        a_rd[i] = 1'b0; a_wr[i] = 1'b0; gap[i] = $urandom_range(0, gap_max);
      end else if (auto_en[i] && !(a_rd[i] | a_wr[i])) begin
        if (gap[i] > 0) gap[i]--;
        else new_req(i);
      end else if (auto_en[i] && $urandom_range(0, 199) == 0) begin
        a_rd[i] = 1'b0; a_wr[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if ((m_rd_req | m_wr_req) && !prev_req) glog.push_back(int'(grant));
    prev_req = m_rd_req | m_wr_req;
    drive();
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while ((busy || (|(p_rd_req | p_wr_req))) && n < 400) begin
      step(); n++;
    end
    chk(tag, 64'(busy || (|(p_rd_req | p_wr_req))), 64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; m_rdy = 1'b1; m_ack = 1'b0; m_data_out = '0;
    for (int i = 0; i < NP; i++) begin
      a_rd[i] = 1'b0; a_wr[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0;
      auto_en[i] = 1'b0; gap[i] = 0;
    end
    gap_max = 0; ack_lat = 4; ctl_wait = 0; drain_len = 1; drain_left = 0;
    refresh_left = 0; rd_word = '0; rand_ctl = 1'b0; prev_req = 1'b0;

    repeat (3) step();
    chk("rst_grant", 64'(grant), 64'(NP - 1));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    step(); step();

    // single read on port 0
    ack_lat = 12; drain_len = 3; rd_word = 64'h1122334455667788;
    a_addr[0] = 26'h0ABCDEF; a_rd[0] = 1'b1;
    step();
    chk("rd_req_rise", 64'(m_rd_req), 64'(1));
    chk("rd_addr", 64'(m_addr), 64'h0ABCDEF);
    n = 0;
    while (!p_ack[0] && n < 40) begin step(); n++; end
    chk("rd_ack_seen", 64'(p_ack[0]), 64'(1));
    chk("rd_data", p_rdata, 64'h1122334455667788);
    settle("rd_settle");

    // write on port 1, long drain
    ack_lat = 4; drain_len = 8;
    a_addr[1] = 26'h1234567; a_wdata[1] = 64'hDEADBEEFCAFEF00D; a_wr[1] = 1'b1;
    step();
    chk("wr_req_rise", 64'(m_wr_req), 64'(1));
    chk("wr_grant", 64'(grant), 64'(1));
    n = 0;
    while (m_wr_req && n < 30) begin step(); n++; end
    for (int j = 0; j < 8; j++) begin
      chk("wr_drain_busy", 64'(busy), 64'(1));
      chk("wr_drain_data", m_data_in, 64'hDEADBEEFCAFEF00D);
      chk("wr_drain_req", 64'(m_wr_req), 64'(0));
      step();
    end
    settle("wr_settle");

    // round robin between ports 0 and 1
    ack_lat = 2; drain_len = 0; gap_max = 0;
    auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    glog.delete();
    n = 0;
    while (glog.size() < 4 && n < 200) begin step(); n++; end
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    chk("rr_count", 64'(glog.size()), 64'(4));
    for (int j = 0; j < 4; j++)
      if (j < glog.size()) chk($sformatf("rr_grant%0d", j), 64'(glog[j]), 64'(j % 2));
    settle("rr_settle");

    // refresh collision: m_rdy low for 20 cycles while port 0 requests
    a_addr[0] = 26'h2A5A5A5; a_rd[0] = 1'b1; m_rdy = 1'b0; refresh_left = 19;
    for (int j = 0; j < 20; j++) begin
      step();
      chk("refresh_no_req", 64'(m_rd_req | m_wr_req), 64'(0));
    end
    step();
    chk("refresh_grant_req", 64'(m_rd_req), 64'(1));
    chk("refresh_grant_idx", 64'(grant), 64'(0));
    settle("refresh_settle");

    // read and write together on port 0 -> read
    a_addr[0] = 26'h3000001; a_wdata[0] = 64'h0123456789ABCDEF; a_rd[0] = 1'b1; a_wr[0] = 1'b1;
    step();
    chk("rdwr_rd", 64'(m_rd_req), 64'(1));
    chk("rdwr_wr", 64'(m_wr_req), 64'(0));
    settle("rdwr_settle");

    // random traffic, stray acks, refreshes and occasional reset
    rand_ctl = 1'b1; gap_max = 3; ack_lat = 3;
    for (int i = 0; i < NP; i++) auto_en[i] = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1; m_ack = 1'b0; ctl_wait = 0; drain_left = 0;
        step();
        rst = 1'b0;
      end else step();
    end
    rand_ctl = 1'b0; ack_lat = 3; drain_len = 1;
    for (int i = 0; i < NP; i++) auto_en[i] = 1'b0;
    settle("rand_settle");

    // timeout: controller never acks
    ack_lat = -1; refresh_left = 0;
    a_addr[0] = 26'h0000123; a_rd[0] = 1'b1;
    step();
    chk("to_req", 64'(m_rd_req), 64'(1));
    repeat (15) step();
    chk("to_err_early", 64'(err_timeout), 64'(0));
    step();
    chk("to_err_set", 64'(err_timeout), 64'(1));
    repeat (5) step();
    chk("to_req_held", 64'(m_rd_req), 64'(1));
    chk("to_err_sticky", 64'(err_timeout), 64'(1));
    rst = 1'b1; a_rd[0] = 1'b0; ctl_wait = 0; drain_left = 0; m_ack = 1'b0;
    step();
    chk("to_rst_err", 64'(err_timeout), 64'(0));
    chk("to_rst_rd", 64'(m_rd_req), 64'(0));
    chk("to_rst_busy", 64'(busy), 64'(0));
    chk("to_rst_grant", 64'(grant), 64'(NP - 1));
    chk("to_rst_addr", 64'(m_addr), 64'(0));
    chk("to_rst_rdata", p_rdata, 64'(0));
    rst = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
